// File: rtl/uart_pkg.sv
// Shared UART constants and transmitter state encoding, common to the TX and RX blocks.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 217;
    localparam int UART_SAMPLE_POINT = 108;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_if.sv
// CPU-facing write/status bus of the UART transmitter plus its serial line.
interface uart_tx_if;

    logic        load;
    logic [15:0] in;
    logic        TX;
    logic [15:0] out;

    modport master (output load, output in, input TX, input out);
    modport slave  (input load, input in, output TX, output out);

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: tick marks the last cycle of each bit, restart holds it at zero.
// Latency: tick is combinational from the count flop; no backpressure.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (clear || restart || tick) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; TX goes low the cycle after an accepted load, frame is 10 bit periods.
// Loads while busy are dropped (out[15] is the busy flag); TX and out are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic     clk,
    input  logic     clear,
    uart_tx_if.slave bus
);

    logic [1:0]  state;
    logic [7:0]  shift;
    logic [3:0]  bit_idx;
    logic        tx_q;
    logic [15:0] out_q;
    logic        tick;
    logic        baud_restart;
    logic        unused_in_hi;

    assign unused_in_hi = ^bus.in[15:8];

    // Holding the counter at zero through IDLE makes every START begin on a fresh count;
    // all other state entries happen on the wrap, where the counter is already returning to 0.
    assign baud_restart = (state == ST_IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .clear   (clear),
        .restart (baud_restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= ST_IDLE;
            shift   <= 8'hFF;
            bit_idx <= 4'd0;
            tx_q    <= 1'b1;
            out_q   <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.load) begin
                        shift <= bus.in[7:0];
                        state <= ST_START;
                        tx_q  <= 1'b0;
                        out_q <= 16'h8000;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        bit_idx <= 4'd0;
                        tx_q    <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift   <= {1'b1, shift[7:1]};
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == 4'd7) begin
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            // shift[1] is the bit that lands in shift[0] at this edge
                            tx_q <= shift[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        out_q <= 16'h0000;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                    out_q <= 16'h0000;
                end
            endcase
        end
    end

    assign bus.TX  = tx_q;
    assign bus.out = out_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, decode, ignored loads, back-to-back and clear cases.
module tb_uart_tx;

    localparam int CPB   = 217;
    localparam int FRAME = 10 * CPB;
    localparam int LOGN  = 4800;

    logic clk;
    logic clear;

    uart_tx_if bus ();

    uart_tx dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        tx_log  [0:LOGN-1];
    logic [15:0] out_log [0:LOGN-1];

    // Expected line level i cycles after the frame's first start-bit cycle.
    function automatic logic exp_tx(input logic [7:0] b, input int i);
        int bitno;
        if (i < 0) return 1'b1;
        bitno = i / CPB;
        if (bitno == 0) return 1'b0;
        if (bitno <= 8) return b[bitno-1];
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_out(input int i);
        return (i >= 0 && i < FRAME) ? 16'h8000 : 16'h0000;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Records TX/out at n negedges. The caller has already driven the first load.
    // Optionally injects a load at a fixed index, or on the first idle sample.
    task automatic capture(input int n, input int inj_at, input logic [15:0] inj_dat,
                           input bit reload_on_idle, output int reload_idx);
        reload_idx = -1;
        for (int i = 0; i < n; i++) begin
            cyc();
            tx_log[i]  = bus.TX;
            out_log[i] = bus.out;
            bus.load   = 1'b0;
            if (i == inj_at) begin
                bus.load = 1'b1;
                bus.in   = inj_dat;
            end else if (reload_on_idle && reload_idx < 0 && bus.out == 16'h0000) begin
                bus.load   = 1'b1;
                bus.in     = inj_dat;
                reload_idx = i;
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        clear    = 1'b1;
        bus.load = 1'b0;
        bus.in   = 16'h0000;
        cyc();
        cyc();
        clear = 1'b0;
        checks++;
        if (bus.TX !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b expected 1", bus.TX);
        end
        checks++;
        if (bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out: got %h expected 0000", bus.out);
        end
        repeat (5) cyc();
        checks++;
        if (bus.TX !== 1'b1 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL idle_hold: got tx=%b out=%h expected tx=1 out=0000", bus.TX, bus.out);
        end
    endtask

    task automatic test_frame_55();
        int bad_tx, bad_out, busy, r;
        bus.load = 1'b1;
        bus.in   = 16'h0055;
        capture(2300, -1, 16'h0000, 1'b0, r);
        bad_tx = 0; bad_out = 0; busy = 0;
        for (int i = 0; i < 2300; i++) begin
            if (tx_log[i] !== exp_tx(8'h55, i)) bad_tx++;
            if (out_log[i] !== exp_out(i)) bad_out++;
            if (out_log[i] === 16'h8000) busy++;
        end
        checks++;
        if (bad_tx != 0) begin
            errors++;
            $display("FAIL frame55_tx: bad samples=%0d expected 0", bad_tx);
        end
        checks++;
        if (bad_out != 0) begin
            errors++;
            $display("FAIL frame55_out: bad samples=%0d expected 0", bad_out);
        end
        checks++;
        if (busy != FRAME) begin
            errors++;
            $display("FAIL frame55_busy_len: got %0d expected %0d", busy, FRAME);
        end
        checks++;
        if (tx_log[CPB-1] !== 1'b0 || tx_log[CPB] !== 1'b1) begin
            errors++;
            $display("FAIL frame55_edge: got %b%b expected 01", tx_log[CPB-1], tx_log[CPB]);
        end
    endtask

    task automatic test_loopback();
        logic [7:0]  rx_byte;
        logic [15:0] rx_out;
        int r;
        bus.load = 1'b1;
        bus.in   = 16'hFFA5;
        capture(2300, -1, 16'h0000, 1'b0, r);
        for (int k = 0; k < 8; k++) rx_byte[k] = tx_log[(k + 1) * CPB + 108];
        rx_out = {8'h00, rx_byte};
        checks++;
        if (tx_log[108] !== 1'b0 || tx_log[9 * CPB + 108] !== 1'b1) begin
            errors++;
            $display("FAIL loop_framing: got start=%b stop=%b expected start=0 stop=1",
                     tx_log[108], tx_log[9 * CPB + 108]);
        end
        checks++;
        if (rx_out !== 16'h00A5) begin
            errors++;
            $display("FAIL loop_data: got %h expected 00a5", rx_out);
        end
    endtask

    task automatic test_ignored_load();
        int bad, r;
        bus.load = 1'b1;
        bus.in   = 16'h0055;
        capture(2300, 500, 16'h00FF, 1'b0, r);
        bad = 0;
        for (int i = 0; i < 2300; i++) begin
            if (tx_log[i] !== exp_tx(8'h55, i) || out_log[i] !== exp_out(i)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL busy_load_ignored: bad samples=%0d expected 0", bad);
        end
        checks++;
        if (out_log[FRAME] !== 16'h0000 || out_log[FRAME-1] !== 16'h8000) begin
            errors++;
            $display("FAIL busy_load_release: got %h,%h expected 8000,0000",
                     out_log[FRAME-1], out_log[FRAME]);
        end
    endtask

    task automatic test_back_to_back();
        int bad1, bad2, ridx;
        bus.load = 1'b1;
        bus.in   = 16'h0000;
        capture(4500, -1, 16'h00FF, 1'b1, ridx);
        checks++;
        if (ridx != FRAME) begin
            errors++;
            $display("FAIL b2b_reload_idx: got %0d expected %0d", ridx, FRAME);
        end
        bad1 = 0; bad2 = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (tx_log[i] !== exp_tx(8'h00, i) || out_log[i] !== exp_out(i)) bad1++;
        end
        for (int i = FRAME + 1; i < 4500; i++) begin
            if (tx_log[i] !== exp_tx(8'hFF, i - FRAME - 1) ||
                out_log[i] !== exp_out(i - FRAME - 1)) bad2++;
        end
        checks++;
        if (bad1 != 0) begin
            errors++;
            $display("FAIL b2b_frame1: bad samples=%0d expected 0", bad1);
        end
        checks++;
        if (bad2 != 0) begin
            errors++;
            $display("FAIL b2b_frame2: bad samples=%0d expected 0", bad2);
        end
        checks++;
        if (tx_log[FRAME] !== 1'b1 || out_log[FRAME] !== 16'h0000 ||
            tx_log[FRAME+1] !== 1'b0 || out_log[FRAME+1] !== 16'h8000) begin
            errors++;
            $display("FAIL b2b_gap: got tx=%b%b out=%h,%h expected tx=10 out=0000,8000",
                     tx_log[FRAME], tx_log[FRAME+1], out_log[FRAME], out_log[FRAME+1]);
        end
    endtask

    task automatic test_clear_mid_frame();
        int bad, r;
        bus.load = 1'b1;
        bus.in   = 16'h0000;
        cyc();
        bus.load = 1'b0;
        repeat (999) cyc();
        checks++;
        if (bus.TX !== 1'b0 || bus.out !== 16'h8000) begin
            errors++;
            $display("FAIL midclr_pre: got tx=%b out=%h expected tx=0 out=8000", bus.TX, bus.out);
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++;
        if (bus.TX !== 1'b1 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL midclr_post: got tx=%b out=%h expected tx=1 out=0000", bus.TX, bus.out);
        end
        cyc();
        cyc();
        bus.load = 1'b1;
        bus.in   = 16'h0055;
        capture(2300, -1, 16'h0000, 1'b0, r);
        bad = 0;
        for (int i = 0; i < 2300; i++) begin
            if (tx_log[i] !== exp_tx(8'h55, i) || out_log[i] !== exp_out(i)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midclr_restart: bad samples=%0d expected 0", bad);
        end
    endtask

    task automatic test_clear_vs_load();
        int bad;
        clear    = 1'b1;
        bus.load = 1'b1;
        bus.in   = 16'h0042;
        cyc();
        clear    = 1'b0;
        bus.load = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.TX !== 1'b1 || bus.out !== 16'h0000) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_priority: bad samples=%0d expected 0", bad);
        end
    endtask

    initial begin
        clear    = 1'b1;
        bus.load = 1'b0;
        bus.in   = 16'h0000;
        test_reset();
        test_frame_55();
        test_loopback();
        test_ignored_load();
        test_back_to_back();
        test_clear_mid_frame();
        test_clear_vs_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
